// File: rtl/dram_pkg.sv
// Shared definitions for the layer-engine DRAM responder: default word and
// address widths, memory map region bases, and word typedefs.
package dram_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 18;

  // Memory map used by the full_conn / conv layer engine
  localparam int unsigned WT_BASE_PS1 = 0;
  localparam int unsigned BS_BASE_PS1 = 48000;
  localparam int unsigned WT_BASE_PS2 = 50000;
  localparam int unsigned BS_BASE_PS2 = 51200;
  localparam int unsigned IFMAP_BASE  = 65536;
  localparam int unsigned OFMAP_BASE  = 131072;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-return delay line: LATENCY stages of valid + data. A data stage only
// loads when its incoming valid is set, so the output word holds between
// returns.
module dram_rd_pipe
  import dram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W_DEF,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]                 vld_q;
  logic [LATENCY-1:0][DATA_WIDTH-1:0] dat_q;

  // Chain index 0 is the pipe input, index LATENCY is the pipe output;
  // this keeps LATENCY=1 free of zero-width slices.
  logic [LATENCY:0]                 vld_chain;
  logic [LATENCY:0][DATA_WIDTH-1:0] dat_chain;

  assign vld_chain = {vld_q, in_vld};
  assign dat_chain = {dat_q, in_data};

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    // One delay stage: valid always shifts, data loads only with valid
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q[g] <= 1'b0;
        dat_q[g] <= '0;
      end else begin
        vld_q[g] <= vld_chain[g];
        if (vld_chain[g]) dat_q[g] <= dat_chain[g];
      end
    end
  end

  assign out_vld  = vld_chain[LATENCY];
  assign out_data = dat_chain[LATENCY];

endmodule

// File: rtl/dram_responder.sv
// DRAM stand-in for the layer-engine master: one read and one write per
// cycle, fixed read latency, saturating transaction counters and a sticky
// out-of-range flag. Define DRAM_WR_BYPASS_EN to make same-address
// read/write collisions return the write data (write-first).
module dram_responder
  import dram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
  parameter int unsigned MEM_WORDS  = 262144,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dram_en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  dram_en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  dram_valid,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic                  oob_err
);

  localparam int unsigned         IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIM = (ADDR_WIDTH + 1)'(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  rd_in_rng;
  logic                  wr_in_rng;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // Range check on the full address so nothing above MEM_WORDS aliases
  assign rd_in_rng = ({1'b0, addr_in}  < MEM_LIM);
  assign wr_in_rng = ({1'b0, addr_out} < MEM_LIM);
  assign rd_idx    = addr_in[IDX_W-1:0];
  assign wr_idx    = addr_out[IDX_W-1:0];

  // Word presented to the read pipe: old contents, optional write forwarding,
  // zero when out of range
  always_comb begin
    rd_word = '0;
    if (rd_in_rng) begin
      rd_word = mem[rd_idx];
`ifdef DRAM_WR_BYPASS_EN
      if (dram_en_wr && (addr_out == addr_in)) rd_word = data_out;
`endif
    end
  end

  // Array write; contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (dram_en_wr && wr_in_rng) mem[wr_idx] <= data_out;
  end

  // Saturating request counters and sticky out-of-range flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      oob_err <= 1'b0;
    end else begin
      if (dram_en_rd && (rd_cnt != '1)) rd_cnt <= rd_cnt + 1'b1;
      if (dram_en_wr && (wr_cnt != '1)) wr_cnt <= wr_cnt + 1'b1;
      if ((dram_en_rd && !rd_in_rng) || (dram_en_wr && !wr_in_rng)) oob_err <= 1'b1;
    end
  end

  dram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (dram_en_rd),
    .in_data  (rd_word),
    .out_vld  (dram_valid),
    .out_data (data_in)
  );

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Memory-side responder for the accelerator's layer-engine DRAM master interface (full_conn, conv layers).
- Serves one read and one write per cycle on independent address ports.
- Returns read data with a fixed, parameterised latency and a matching valid strobe.
- Port names mirror the master's nets so the top level connects them by name; it is the simulation/FPGA stand-in for DRAM.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 18, address width.
- MEM_WORDS, 262144, implemented words; addresses >= MEM_WORDS are out of range.
- RD_LATENCY, 1, cycles from read request to data; legal range 1..4.
- CNT_WIDTH, 24, width of the transaction counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- dram_en_rd  in  1  read request this cycle.
- addr_in  in  ADDR_WIDTH  read address.
- dram_en_wr  in  1  write request this cycle.
- addr_out  in  ADDR_WIDTH  write address.
- data_out  in  DATA_WIDTH  write data.
- data_in  out  DATA_WIDTH  read data.
- dram_valid  out  1  data_in carries a returned word this cycle.
- rd_cnt  out  CNT_WIDTH  accepted reads, saturating.
- wr_cnt  out  CNT_WIDTH  accepted writes, saturating.
- oob_err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (async assert, release on the clock): data_in=0, dram_valid=0, rd_cnt=0, wr_cnt=0, oob_err=0, read pipeline flushed.
- Memory array is not reset; contents survive rst.
- No backpressure. Every request is accepted in the cycle it is presented.
- Read issue: dram_en_rd=1 at edge T.
  - Array is sampled at T with addr_in.
  - Word moves through RD_LATENCY-1 further register stages.
  - At RD_LATENCY=1: data_in=mem[addr_in] and dram_valid=1 during the cycle after T, which is the master's load cycle.
- Back-to-back reads: one word per cycle, in order, no bubbles.
- data_in holds the last returned word while dram_valid=0.
- Write: dram_en_wr=1 at edge T writes data_out to mem[addr_out] at T.
- Simultaneous read and write, different addresses: both serviced.
- Simultaneous read and write, same address: read-before-write, so the read returns the old word (see the optional feature).
- A write after a read has issued never alters that read's returned data, for any RD_LATENCY.
- Out of range (address >= MEM_WORDS):
  - Read returns 0 with dram_valid still asserted.
  - Write is dropped.
  - oob_err sets and stays set until rst.
  - rd_cnt/wr_cnt still count the request.
- Counters increment by 1 per accepted request and saturate at 2^CNT_WIDTH-1 with no wrap.
- Reset mid-operation: in-flight reads are discarded and produce no dram_valid pulses after release. Writes already committed remain.
- Address arithmetic is unsigned and width-exact; no aliasing/wrap of addresses above MEM_WORDS.

Optional Feature:
- Macro DRAM_WR_BYPASS_EN.
  - Defined: same-cycle same-address read/write forwards data_out to the read (write-first).
  - Undefined: read-before-write returns the old word.
- Either way, out-of-range collisions return 0.

Decomposition:
- Shared package dram_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - Region bases: WT_BASE_PS1=0, BS_BASE_PS1=48000, WT_BASE_PS2=50000, BS_BASE_PS2=51200, IFMAP_BASE=65536, OFMAP_BASE=131072.
  - A typedef for address and data words.
- Sub-module dram_rd_pipe: a RD_LATENCY-deep valid+data delay line with async reset on the valid bits.

Test Plan:
1. Reset then write mem[65536]=32'h0001_0000, read 65536 at T -> data_in=32'h0001_0000 with dram_valid=1 at T+1 (RD_LATENCY=1); rd_cnt=1, wr_cnt=1.
2. Burst of 400 consecutive reads from 65536..65935, preloaded with index values -> 400 contiguous dram_valid cycles returning 0..399 in order, no gaps.
3. Same cycle: write 5 to addr 131072 and read 131072, old value 7 -> returns 7 without the macro, 5 with DRAM_WR_BYPASS_EN; next read returns 5.
4. RD_LATENCY=3: read addr 100 (value 9) at T, write 11 to addr 100 at T+1 -> data_in=9 at T+3.
5. MEM_WORDS=65536: read 70000 -> data_in=0, dram_valid=1, oob_err=1. Write to 70000 is dropped. oob_err stays 1 until rst.
6. Assert rst with 2 reads in flight (RD_LATENCY=3) -> dram_valid stays 0 after release; counters 0; previously written mem[131072]=5 still reads 5.
